// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-port sync-read memory between fetch (I) and load/store (D).
// Latency : grant is combinational in the request cycle; read data returns 1 cycle after grant.
// Backpressure: a requester holds req/operands until it sees its gnt; the loser simply waits.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   i_req/i_addr                 fetch request (read only)
//   i_gnt/i_rvalid/i_rdata       fetch accept, fetch data valid, fetch data
//   d_req/d_we/d_addr/d_wdata    load/store request
//   d_gnt/d_rvalid/d_rdata       load/store accept, load data valid, load data
//   m_addr/m_in/m_we/m_out       memory port (m_out is the memory's registered read data)
//
// Build option: ARB_ROUND_ROBIN_EN selects alternating priority on conflicts instead of
// fixed D priority with the I starvation guard (stall_cnt / MAX_STALL).
module mem_port_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_STALL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [31:0]      i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic [WIDTH-1:0] i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [31:0]      d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic [31:0]      m_addr,
  output logic [WIDTH-1:0] m_in,
  output logic             m_we,
  input  logic [WIDTH-1:0] m_out
);

  logic        i_win;
  logic        d_win;
  logic        prefer_i;   // on a conflict, I takes the port when set
  logic [31:0] last_addr;  // address of the most recent grant, held while idle
  logic [1:0]  owner;      // {I read in flight, D read in flight}

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers who won the last conflict; reset to I so D wins the first one.
  logic last_winner_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_winner_i <= 1'b1;
    end else if (i_req && d_req) begin
      last_winner_i <= i_win;
    end
  end

  assign prefer_i = ~last_winner_i;
`else
  localparam logic [7:0] STALL_MAX = 8'(MAX_STALL);

  // Counts consecutive cycles I asked and lost; once it reaches STALL_MAX
  // I is forced through on the next conflict.
  logic [7:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 8'd0;
    end else if (!i_req || i_win) begin
      stall_cnt <= 8'd0;
    end else if (d_win && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end

  assign prefer_i = (stall_cnt == STALL_MAX);
`endif

  // Arbitration: nothing is granted while reset is high, so no access can
  // start and m_we stays low.
  always_comb begin
    i_win = 1'b0;
    d_win = 1'b0;
    if (!rst) begin
      if (i_req && d_req) begin
        i_win = prefer_i;
        d_win = ~prefer_i;
      end else begin
        i_win = i_req;
        d_win = d_req;
      end
    end
  end

  assign i_gnt = i_win;
  assign d_gnt = d_win;

  // Memory port drive.
  always_comb begin
    m_addr = last_addr;
    m_in   = '0;
    m_we   = 1'b0;
    if (d_win) begin
      m_addr = d_addr;
      m_in   = d_wdata;
      m_we   = d_we;
    end else if (i_win) begin
      m_addr = i_addr;
    end
  end

  // Address hold and response ownership. The owner register lines up with the
  // memory's one-cycle registered read, so rvalid coincides with m_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_addr <= 32'd0;
      owner     <= 2'b00;
    end else begin
      if (i_win || d_win) begin
        last_addr <= m_addr;
      end
      owner <= {i_win, d_win & ~d_we};
    end
  end

  assign i_rvalid = owner[1];
  assign d_rvalid = owner[0];
  assign i_rdata  = m_out;
  assign d_rdata  = m_out;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: hand-written vector table, a conflict sequence and
// randomized traffic, all checked against a cycle-level reference model.
module tb_mem_port_arbiter;

  localparam int WIDTH     = 32;
  localparam int MAX_STALL = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_req;
  logic [31:0]      i_addr;
  logic             i_gnt;
  logic             i_rvalid;
  logic [WIDTH-1:0] i_rdata;
  logic             d_req;
  logic             d_we;
  logic [31:0]      d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic             d_gnt;
  logic             d_rvalid;
  logic [WIDTH-1:0] d_rdata;
  logic [31:0]      m_addr;
  logic [WIDTH-1:0] m_in;
  logic             m_we;
  logic [WIDTH-1:0] m_out;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(WIDTH), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_in(m_in), .m_we(m_we), .m_out(m_out)
  );

  function automatic logic [31:0] init_word(input int k);
    return 32'hA500_0000 ^ (32'(k) * 32'h0101_0101);
  endfunction

  // Single-port synchronous memory, write-first, registered output, 256 words.
  logic [WIDTH-1:0] phys_mem [0:255];
  bit               mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < 256; k++) phys_mem[k] <= init_word(k);
      mem_ready <= 1'b1;
    end else if (m_we) begin
      phys_mem[m_addr[7:0]] <= m_in;
      m_out                 <= m_in;
    end else begin
      m_out <= phys_mem[m_addr[7:0]];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          stall;          // consecutive cycles I has asked and lost
  bit          rr_last_i;      // last conflict winner was I
  logic [31:0] ref_last;       // address of last grant
  bit          pend_i, pend_d; // read response due this cycle
  logic [31:0] pend_data;
  logic [31:0] ref_mem [0:255];
  bit          eig, edg;       // expected grants in the current cycle

  // Called mid-cycle: computes expected grants and port values, compares.
  task automatic model_eval();
    logic [31:0] exp_addr;
    if (rst) begin
      stall = 0; rr_last_i = 1'b1; ref_last = 32'd0; pend_i = 1'b0; pend_d = 1'b0;
    end
    eig = 1'b0;
    edg = 1'b0;
    if (!rst) begin
      if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        edg = rr_last_i;
`else
        edg = (stall != MAX_STALL);
`endif
        eig = !edg;
      end else begin
        eig = i_req;
        edg = d_req;
      end
    end
    exp_addr = edg ? d_addr : (eig ? i_addr : ref_last);
    chk("i_gnt", 32'(i_gnt), 32'(eig));
    chk("d_gnt", 32'(d_gnt), 32'(edg));
    chk("m_we", 32'(m_we), 32'(edg && d_we));
    chk("m_addr", m_addr, exp_addr);
    chk("m_in", m_in, edg ? d_wdata : 32'd0);
    chk("i_rvalid", 32'(i_rvalid), 32'(pend_i));
    chk("d_rvalid", 32'(d_rvalid), 32'(pend_d));
    if (pend_i) chk("i_rdata", i_rdata, pend_data);
    if (pend_d) chk("d_rdata", d_rdata, pend_data);
  endtask

  // Called just after the clock edge: commits the cycle's effects.
  task automatic model_update();
    if (rst) begin
      pend_i = 1'b0;
      pend_d = 1'b0;
    end else begin
      pend_i = eig;
      pend_d = edg && !d_we;
      if (eig) pend_data = ref_mem[i_addr[7:0]];
      else if (edg && !d_we) pend_data = ref_mem[d_addr[7:0]];
      if (edg && d_we) ref_mem[d_addr[7:0]] = d_wdata;
      if (eig) ref_last = i_addr;
      else if (edg) ref_last = d_addr;
      if (!i_req || eig) stall = 0;
      else if (stall < MAX_STALL) stall++;
      if (i_req && d_req) rr_last_i = eig;
    end
  endtask

  task automatic tick_check();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick_adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, ireq, dreq, dwe;
    logic [31:0] iaddr, daddr, wdata;
    logic        eig, edg, eiv, edv;
    logic [31:0] edat;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic r, input logic ir, input logic dr, input logic we,
                              input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                              input logic gi, input logic gd, input logic vi, input logic vd,
                              input logic [31:0] dat);
    vec_t v;
    v.rst = r; v.ireq = ir; v.dreq = dr; v.dwe = we;
    v.iaddr = ia; v.daddr = da; v.wdata = wd;
    v.eig = gi; v.edg = gd; v.eiv = vi; v.edv = vd; v.edat = dat;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
    stall = 0; rr_last_i = 1'b1; ref_last = 32'd0; pend_i = 1'b0; pend_d = 1'b0; pend_data = 32'd0;

    //              rst ir dr we  iaddr  daddr  wdata          gi gd vi vd data
    tbl[0]  = mk(1, 1, 1, 0, 32'h10, 32'h7, 32'h0,          0, 0, 0, 0, 32'h0);
    tbl[1]  = mk(1, 1, 1, 0, 32'h10, 32'h7, 32'h0,          0, 0, 0, 0, 32'h0);
    tbl[2]  = mk(0, 0, 0, 0, 32'h10, 32'h7, 32'h0,          0, 0, 0, 0, 32'h0);
    tbl[3]  = mk(0, 0, 0, 0, 32'h10, 32'h7, 32'h0,          0, 0, 0, 0, 32'h0);
    tbl[4]  = mk(0, 1, 0, 0, 32'h10, 32'h7, 32'h0,          1, 0, 0, 0, 32'h0);
    tbl[5]  = mk(0, 1, 0, 0, 32'h10, 32'h7, 32'h0,          1, 0, 1, 0, init_word(16));
    tbl[6]  = mk(0, 1, 0, 0, 32'h10, 32'h7, 32'h0,          1, 0, 1, 0, init_word(16));
    tbl[7]  = mk(0, 0, 0, 0, 32'h10, 32'h7, 32'h0,          0, 0, 1, 0, init_word(16));
    tbl[8]  = mk(0, 0, 1, 1, 32'h10, 32'h5, 32'hDEADBEEF,   0, 1, 0, 0, 32'h0);
    tbl[9]  = mk(0, 0, 1, 0, 32'h10, 32'h5, 32'h0,          0, 1, 0, 0, 32'h0);
    tbl[10] = mk(0, 0, 0, 0, 32'h10, 32'h5, 32'h0,          0, 0, 0, 1, 32'hDEADBEEF);
    tbl[11] = mk(0, 0, 1, 0, 32'h10, 32'h7, 32'h0,          0, 1, 0, 0, 32'h0);
    tbl[12] = mk(1, 0, 0, 0, 32'h10, 32'h7, 32'h0,          0, 0, 0, 0, 32'h0);
    tbl[13] = mk(0, 0, 0, 0, 32'h10, 32'h7, 32'h0,          0, 0, 0, 0, 32'h0);
    tbl[14] = mk(1, 0, 1, 0, 32'h10, 32'h7, 32'h0,          0, 0, 0, 0, 32'h0);
    tbl[15] = mk(0, 0, 0, 0, 32'h10, 32'h7, 32'h0,          0, 0, 0, 0, 32'h0);

    for (int n = 0; n < 16; n++) begin
      rst = tbl[n].rst; i_req = tbl[n].ireq; d_req = tbl[n].dreq; d_we = tbl[n].dwe;
      i_addr = tbl[n].iaddr; d_addr = tbl[n].daddr; d_wdata = tbl[n].wdata;
      tick_check();
      chk($sformatf("row%0d i_gnt", n), 32'(i_gnt), 32'(tbl[n].eig));
      chk($sformatf("row%0d d_gnt", n), 32'(d_gnt), 32'(tbl[n].edg));
      chk($sformatf("row%0d i_rvalid", n), 32'(i_rvalid), 32'(tbl[n].eiv));
      chk($sformatf("row%0d d_rvalid", n), 32'(d_rvalid), 32'(tbl[n].edv));
      if (tbl[n].eiv) chk($sformatf("row%0d i_rdata", n), i_rdata, tbl[n].edat);
      if (tbl[n].edv) chk($sformatf("row%0d d_rdata", n), d_rdata, tbl[n].edat);
      tick_adv();
    end

    // Both requesters held high: starvation guard (or alternation) pattern.
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 32'h20; d_addr = 32'h30;
    for (int k = 0; k < 10; k++) begin
      logic exp_d;
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = (k % (MAX_STALL + 1) != MAX_STALL);
`endif
      tick_check();
      chk($sformatf("conflict%0d d_gnt", k), 32'(d_gnt), 32'(exp_d));
      chk($sformatf("conflict%0d i_gnt", k), 32'(i_gnt), 32'(!exp_d));
      tick_adv();
    end
    i_req = 1'b0; d_req = 1'b0;
    tick_check();
    tick_adv();

    // Randomized traffic; a requester only changes its operands after a grant.
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!i_req || eig) begin
        r = $urandom;
        i_req  = ($urandom_range(0, 1) == 1);
        i_addr = {r[31:8], 4'h0, r[3:0]};
      end
      if (!d_req || edg) begin
        r = $urandom;
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = {r[31:8], 4'h0, r[7:4]};
        d_wdata = $urandom;
      end
      tick_check();
      tick_adv();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous-read memory (1-cycle read latency, write-first-cycle, registered output) between the instruction-fetch requester (I) and the load/store requester (D) of the MIPS core.
- Grants at most one access per cycle, drives the memory port, and routes the read data back to the requester that issued it.
- Default policy is fixed priority, D over I, plus a starvation guard for I.

Parameters:
- WIDTH, 32, data word width; matches the memory word width.
- MAX_STALL, 4, consecutive cycles I may lose arbitration before it is forced to win; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- i_req  in  1  instruction fetch request (read only)
- i_addr  in  32  fetch word address
- i_gnt  out  1  fetch accepted this cycle (combinational)
- i_rvalid  out  1  fetch data valid this cycle
- i_rdata  out  WIDTH  fetch data
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data word address
- d_wdata  in  WIDTH  write data
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  load data valid this cycle
- d_rdata  out  WIDTH  load data
- m_addr  out  32  memory address
- m_in  out  WIDTH  memory write data
- m_we  out  1  memory write enable
- m_out  in  WIDTH  memory registered read data

Behaviour:
- Handshake: a requester holds its req and operands stable until it sees gnt high in the same cycle. The access completes at that clk edge.
- Arbitration, combinational in cycle N:
  - Only D requests: D wins.
  - Only I requests: I wins.
  - Both request: D wins, unless stall_cnt == MAX_STALL, in which case I wins.
  - At most one of i_gnt/d_gnt is high.
- Memory port:
  - When D wins: m_addr=d_addr, m_in=d_wdata, m_we=d_we.
  - When I wins: m_addr=i_addr, m_in=0, m_we=0.
  - When nobody wins: m_addr holds the last granted address, m_in=0, m_we=0.
  - m_we is 0 whenever rst is high.
- Response routing:
  - Registered 2-bit owner, {I-read, D-read}, captured at each edge from the grant and write flag.
  - A granted read produces rvalid to its owner exactly 1 cycle later, with rdata equal to m_out.
  - A granted write produces no rvalid.
  - i_rdata and d_rdata both carry m_out and are qualified only by their rvalid.
- Throughput: back-to-back grants every cycle are allowed, so at most one read is in flight at a time.
- stall_cnt, 8-bit:
  - Increments when I requests and D wins.
  - Clears when I is granted or i_req is low.
  - Saturates at MAX_STALL.
- Reset value 0 for every register: owner, stall_cnt, last address. Consequently i_rvalid = d_rvalid = 0, m_addr = 0, and m_we = 0 on reset.
- Reset mid-operation: a read granted in the cycle rst asserts produces no rvalid, and the response is dropped.
- Read of the address written in the previous cycle returns the new data, because of memory ordering. The arbiter adds no forwarding.
- Addresses pass through unmodified. The memory truncates them to its index width.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on a conflict the winner alternates. A 1-bit last_winner register (reset = I, so D wins the first conflict) gives priority to the requester that did not win the last conflict. stall_cnt and MAX_STALL are unused.
- Undefined: fixed D priority with the starvation guard, as above.

Test Plan:
- Reset: hold rst with i_req=d_req=1 → i_gnt, d_gnt and m_we are 0 during rst. After release, both rvalid stay 0 until the first grant.
- I only: i_req, i_addr=0x10 for 3 cycles → i_gnt=1 each cycle. i_rvalid=1 on cycles 2–4 with i_rdata = mem[0x10].
- D write then read: d_we=1, d_addr=5, d_wdata=0xDEADBEEF, then a read of addr 5 → no d_rvalid after the write. d_rvalid=1 with 0xDEADBEEF one cycle after the read grant. i_rvalid stays 0.
- Conflict starvation, macro undefined, MAX_STALL=4: i_req and d_req held high → D granted cycles 0–3, I granted cycle 4, D cycles 5–8, I cycle 9.
- Conflict with ARB_ROUND_ROBIN_EN: both requesters held high → grants alternate D, I, D, I starting with D. Each read's rvalid goes to the correct owner.
- Reset mid-read: grant a D read at address 7 and assert rst in that same cycle → d_rvalid stays 0 on the following cycle.
